fsm_seq_gen: RTL

FSM_SEQ_GEN -- requirements
Module: fsm_seq_gen

---
 rtl/fsm_seq_pkg.sv | 21 ++
 rtl/fsm_seq_sat_cnt.sv | 19 +
 rtl/fsm_seq_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared types and constants for the sequence generator.
// The symbol picker keeps the packed-symbol layout defined in one place.
package fsm_seq_pkg;

  localparam int MAX_LEN = 8;
  localparam int SYM_W   = 2;
  localparam int IDX_W   = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST,
    ST_SEND,
    ST_DONE
  } state_t;

  function automatic logic [SYM_W-1:0] sym_at(input logic [MAX_LEN*SYM_W-1:0] seq,
                                              input logic [IDX_W-1:0] idx);
    return seq[SYM_W*idx +: SYM_W];
  endfunction

endpackage

// File: rtl/fsm_seq_sat_cnt.sv
// Saturating up-counter that counts sequences ending with a hit.
module fsm_seq_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fsm_seq_gen.sv
// Stimulus sequencer: resets an attached DUT, plays a latched symbol
// sequence into it and records whether its detector fired.
module fsm_seq_gen
  import fsm_seq_pkg::*;
#(
  parameter int GAP_CYC = 1,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_start,
  input  logic [3:0]               i_len,
  input  logic [MAX_LEN*SYM_W-1:0] i_seq,
  input  logic                     i_det,
  output logic                     o_dut_rstn,
  output logic [SYM_W-1:0]         o_symbol,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_hit,
  output logic                     o_err,
  output logic [CNT_W-1:0]         o_hit_cnt
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t                     state;
  logic [3:0]                 gap_cnt;
  logic [IDX_W-1:0]           idx;
  logic [3:0]                 len_q;
  logic [MAX_LEN*SYM_W-1:0]   seq_q;
  logic                       hit_q;
  logic                       len_ok;
  logic                       cnt_inc;

  assign len_ok  = (i_len != 4'd0) && (i_len <= 4'(MAX_LEN));
  // The counter updates on the same edge that raises o_done, so both agree.
  assign cnt_inc = (state == ST_DONE) && (hit_q || i_det);

  fsm_seq_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_inc (cnt_inc),
    .o_cnt (o_hit_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      gap_cnt    <= '0;
      idx        <= '0;
      len_q      <= '0;
      seq_q      <= '0;
      hit_q      <= 1'b0;
      o_dut_rstn <= 1'b0;
      o_symbol   <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_hit      <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_hit  <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            if (len_ok) begin
              seq_q      <= i_seq;
              len_q      <= i_len;
              idx        <= '0;
              hit_q      <= 1'b0;
              gap_cnt    <= '0;
              state      <= ST_RST;
              o_busy     <= 1'b1;
              o_dut_rstn <= 1'b0;
              o_symbol   <= '0;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        ST_RST: begin
          if (gap_cnt == GAP_LAST) begin
            state      <= ST_SEND;
            o_dut_rstn <= 1'b1;
            o_symbol   <= sym_at(seq_q, '0);
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        ST_SEND: begin
          // The first symbol's edge is skipped: the DUT has not produced a Moore result yet.
          if ((idx != '0) && i_det) begin
            hit_q <= 1'b1;
          end
          if ({1'b0, idx} == (len_q - 4'd1)) begin
            state    <= ST_DONE;
            o_symbol <= '0;
          end else begin
            idx      <= idx + IDX_W'(1);
            o_symbol <= sym_at(seq_q, idx + IDX_W'(1));
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          o_busy     <= 1'b0;
          o_dut_rstn <= 1'b0;
          o_done     <= 1'b1;
          o_hit      <= hit_q | i_det;
          hit_q      <= hit_q | i_det;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
